// File: rtl/peak_find_frame.sv
// Frame peak finder: scans FRAME_LEN valid samples, reports the largest value
// (or largest magnitude) and its position once per completed frame.
module peak_find_frame #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 256,
  parameter int ABS_MODE  = 0,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic                    v_i,
  input  logic                    clr_i,
  output logic signed [WIDTH-1:0] peak_o,
  output logic [IDX_W-1:0]        peak_idx_o,
  output logic                    vout_o,
  output logic                    busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam logic signed [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MaxVal  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [IDX_W-1:0]        LastIdx = IDX_W'(FRAME_LEN - 1);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] run_peak_q, run_peak_d;
  logic [IDX_W-1:0]        run_idx_q, run_idx_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] peak_q, peak_d;
  logic [IDX_W-1:0]        peak_idx_q, peak_idx_d;
  logic                    vout_q, vout_d;
  logic signed [WIDTH-1:0] cmp;
  logic                    is_last;
  logic                    is_greater;

  // Compare value: raw sample, or its magnitude with the most negative code clamped to max.
  always_comb begin
    cmp = x_i;
    if (ABS_MODE != 0 && x_i[WIDTH-1]) begin
      if (x_i == MinVal) begin
        cmp = MaxVal;
      end else begin
        cmp = -x_i;
      end
    end
  end

  assign is_last    = (state_q == ACC) && (cnt_q == LastIdx);
  assign is_greater = (cmp > run_peak_q);

  // State register; reset drops any partial frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: abort wins, a first sample opens a frame, the last sample closes it.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else if (v_i) begin
      if (state_q == IDLE) begin
        state_d = ACC;
      end else if (is_last) begin
        state_d = IDLE;
      end
    end
  end

  // Running peak tracking and result capture; strict compare keeps the earliest tie.
  always_comb begin
    run_peak_d = run_peak_q;
    run_idx_d  = run_idx_q;
    cnt_d      = cnt_q;
    peak_d     = peak_q;
    peak_idx_d = peak_idx_q;
    vout_d     = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (v_i) begin
      if (state_q == IDLE) begin
        run_peak_d = cmp;
        run_idx_d  = '0;
        cnt_d      = IDX_W'(1);
      end else begin
        if (is_greater) begin
          run_peak_d = cmp;
          run_idx_d  = cnt_q;
        end
        if (is_last) begin
          cnt_d      = '0;
          peak_d     = is_greater ? cmp : run_peak_q;
          peak_idx_d = is_greater ? cnt_q : run_idx_q;
          vout_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_peak_q <= '0;
      run_idx_q  <= '0;
      cnt_q      <= '0;
      peak_q     <= '0;
      peak_idx_q <= '0;
      vout_q     <= 1'b0;
    end else begin
      run_peak_q <= run_peak_d;
      run_idx_q  <= run_idx_d;
      cnt_q      <= cnt_d;
      peak_q     <= peak_d;
      peak_idx_q <= peak_idx_d;
      vout_q     <= vout_d;
    end
  end

  // Outputs come straight from registers; busy marks a partially filled frame.
  always_comb begin
    peak_o     = peak_q;
    peak_idx_o = peak_idx_q;
    vout_o     = vout_q;
    busy_o     = (state_q == ACC);
  end

endmodule

// File: tb/tb_peak_find_frame.sv
// Bench for peak_find_frame with FRAME_LEN=4, WIDTH=16: one signed instance and
// one magnitude instance, results checked against a queue of expected frames.
module tb_peak_find_frame;

  localparam int W  = 16;
  localparam int FL = 4;

  logic               clk;
  logic               rst_n;
  logic signed [W-1:0] x;
  logic               v0, v1, clr0, clr1;
  logic signed [W-1:0] peak0, peak1;
  logic [1:0]         idx0, idx1;
  logic               vout0, vout1, busy0, busy1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic signed [W-1:0] peak;
    logic [1:0]          idx;
    int                  due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  peak_find_frame #(.WIDTH(W), .FRAME_LEN(FL), .ABS_MODE(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .x_i(x), .v_i(v0), .clr_i(clr0),
    .peak_o(peak0), .peak_idx_o(idx0), .vout_o(vout0), .busy_o(busy0)
  );

  peak_find_frame #(.WIDTH(W), .FRAME_LEN(FL), .ABS_MODE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .x_i(x), .v_i(v1), .clr_i(clr1),
    .peak_o(peak1), .peak_idx_o(idx1), .vout_o(vout1), .busy_o(busy1)
  );

  // Free-running clock and an edge counter used to time result pulses.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard for the signed instance: every pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (vout0) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb0_unexpected_vout: got vout=1 at cycle %0d, expected none", cyc);
      end else begin
        e0 = q0.pop_front();
        if (peak0 !== e0.peak || idx0 !== e0.idx || cyc !== e0.due) begin
          fails++;
          $display("[TB] FAIL sb0_frame: got peak=%0d idx=%0d cycle=%0d, expected peak=%0d idx=%0d cycle=%0d",
                   peak0, idx0, cyc, e0.peak, e0.idx, e0.due);
        end
      end
    end
  end

  // Scoreboard for the magnitude instance.
  always @(negedge clk) begin
    if (vout1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("[TB] FAIL sb1_unexpected_vout: got vout=1 at cycle %0d, expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        if (peak1 !== e1.peak || idx1 !== e1.idx || cyc !== e1.due) begin
          fails++;
          $display("[TB] FAIL sb1_frame: got peak=%0d idx=%0d cycle=%0d, expected peak=%0d idx=%0d cycle=%0d",
                   peak1, idx1, cyc, e1.peak, e1.idx, e1.due);
        end
      end
    end
  end

  // Overall time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic signed [W-1:0] xv, input logic a, input logic b, input logic c);
    @(negedge clk);
    x    = xv;
    v0   = a;
    v1   = b;
    clr0 = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called right after the last sample is driven: result is due on the next edge.
  task automatic expect0(input logic signed [W-1:0] p, input logic [1:0] i);
    exp_t e;
    e.peak = p; e.idx = i; e.due = cyc + 1;
    q0.push_back(e);
  endtask

  task automatic expect1(input logic signed [W-1:0] p, input logic [1:0] i);
    exp_t e;
    e.peak = p; e.idx = i; e.due = cyc + 1;
    q1.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_missing_vout: got %0d/%0d frames still pending, expected 0/0",
               name, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  function automatic logic signed [W-1:0] mag(input logic signed [W-1:0] a);
    if (a == -16'sd32768) return 16'sd32767;
    if (a < 0) return -a;
    return a;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    x = '0; v0 = 1'b0; v1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_peak0", peak0, 0);
    checkOutput("reset_idx0", idx0, 0);
    checkOutput("reset_vout0", vout0, 0);
    checkOutput("reset_busy0", busy0, 0);
    checkOutput("reset_peak1", peak1, 0);
    checkOutput("reset_busy1", busy1, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_negative_seed();
    applyStimulus(-16'sd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(-16'sd3, 1'b1, 1'b0, 1'b0);
    checkOutput("neg_busy_after_first", busy0, 1);
    applyStimulus(-16'sd9, 1'b1, 1'b0, 1'b0);
    applyStimulus(-16'sd7, 1'b1, 1'b0, 1'b0);
    expect0(-16'sd3, 2'd1);
    idle(1);
    checkOutput("neg_busy_after_frame", busy0, 0);
    drain("neg");
  endtask

  task automatic test_back_to_back();
    applyStimulus(16'sd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd1, 1'b1, 1'b0, 1'b0);
    expect0(16'sd7, 2'd0);
    applyStimulus(16'sd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd3, 1'b1, 1'b0, 1'b0);
    checkOutput("b2b_peak_held_midframe", peak0, 7);
    checkOutput("b2b_idx_held_midframe", idx0, 0);
    applyStimulus(16'sd4, 1'b1, 1'b0, 1'b0);
    expect0(16'sd4, 2'd3);
    idle(1);
    drain("b2b");
  endtask

  task automatic test_abs_saturation();
    applyStimulus(16'sd100, 1'b0, 1'b1, 1'b0);
    applyStimulus(-16'sd32768, 1'b0, 1'b1, 1'b0);
    applyStimulus(-16'sd200, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'sd5, 1'b0, 1'b1, 1'b0);
    expect1(16'sd32767, 2'd1);
    applyStimulus(-16'sd7, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'sd3, 1'b0, 1'b1, 1'b0);
    applyStimulus(-16'sd32767, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'sd32767, 1'b0, 1'b1, 1'b0);
    expect1(16'sd32767, 2'd2);
    idle(1);
    drain("abs");
  endtask

  task automatic test_clear();
    applyStimulus(16'sd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd9, 1'b1, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'sd3, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_busy_cleared", busy0, 0);
    checkOutput("clr_peak_kept", peak0, 4);
    checkOutput("clr_idx_kept", idx0, 3);
    applyStimulus(16'sd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd8, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd4, 1'b1, 1'b0, 1'b0);
    expect0(16'sd8, 2'd2);
    applyStimulus(16'sd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd1, 1'b1, 1'b0, 1'b1);
    idle(2);
    checkOutput("clr_last_busy", busy0, 0);
    checkOutput("clr_last_peak_kept", peak0, 8);
    applyStimulus(16'sd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd0, 1'b1, 1'b0, 1'b0);
    expect0(16'sd5, 2'd1);
    idle(1);
    drain("clr");
  endtask

  task automatic test_gaps();
    logic signed [W-1:0] s [4] = '{16'sd10, 16'sd40, 16'sd20, 16'sd30};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(s[k], 1'b1, 1'b0, 1'b0);
      if (k == 3) begin
        expect0(16'sd40, 2'd1);
      end else begin
        int g;
        g = 3 + int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) begin
          applyStimulus(16'sd999, 1'b0, 1'b0, 1'b0);
          checkOutput("gap_busy", busy0, 1);
          checkOutput("gap_peak_held", peak0, 5);
          checkOutput("gap_idx_held", idx0, 1);
        end
      end
    end
    idle(1);
    drain("gap");
  endtask

  task automatic test_reset_midframe();
    applyStimulus(16'sd11, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'sd12, 1'b1, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_peak0", peak0, 0);
    checkOutput("rstmid_idx0", idx0, 0);
    checkOutput("rstmid_busy0", busy0, 0);
    checkOutput("rstmid_busy1", busy1, 0);
    checkOutput("rstmid_peak1", peak1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'sd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'sd3, 1'b1, 1'b0, 1'b0);
    expect0(16'sd6, 2'd0);
    idle(1);
    drain("rstmid");
  endtask

  task automatic test_random_frames();
    logic signed [W-1:0] s;
    logic signed [W-1:0] best0, best1;
    logic [1:0]          bi0, bi1;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < FL; k++) begin
        s = W'($urandom());
        if (f == 1 && k == 2) s = -16'sd32768;
        if (k == 0 || s > best0) begin best0 = s; bi0 = 2'(k); end
        if (k == 0 || mag(s) > best1) begin best1 = mag(s); bi1 = 2'(k); end
        applyStimulus(s, 1'b1, 1'b1, 1'b0);
      end
      expect0(best0, bi0);
      expect1(best1, bi1);
    end
    idle(1);
    drain("rand");
  endtask

  // Scenario sequence and final summary.
  initial begin
    test_reset();
    test_negative_seed();
    test_back_to_back();
    test_abs_saturation();
    test_clear();
    test_gaps();
    test_reset_midframe();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/peak_find_frame.md
PEAK_FIND_FRAME -- requirements
Module: peak_find_frame

Interface
REQ-001 Parameter WIDTH, default 16: sample width in bits, two's complement; legal range 2..32.
REQ-002 Parameter FRAME_LEN, default 256: valid samples per frame; legal range 2..65536.
REQ-003 Parameter ABS_MODE, default 0: 0 = compare signed values; 1 = compare magnitudes.
REQ-004 Local parameter IDX_W = clog2(FRAME_LEN): width of the index output.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low: assertion (0) clears state immediately; release is synchronised externally.
REQ-007 x  input  WIDTH  signed sample.
REQ-008 v  input  1  sample valid; x is consumed on every rising edge where v=1.
REQ-009 clr  input  1  synchronous frame abort; discards the partial frame.
REQ-010 peak  output  WIDTH  frame peak value, signed; in ABS_MODE=1 a non-negative magnitude.
REQ-011 peak_idx  output  IDX_W  position 0..FRAME_LEN-1 of the peak within its frame.
REQ-012 vout  output  1  single-cycle pulse: peak/peak_idx just updated with a completed frame.
REQ-013 busy  output  1  high while a partial frame (1..FRAME_LEN-1 samples) is held.

Function
REQ-014 The block SHALL have two states: IDLE (no samples accumulated) and ACC (1..FRAME_LEN-1 samples accumulated).
REQ-015 Working registers: run_peak (WIDTH), run_idx (IDX_W), sample counter cnt (IDX_W); cnt counts accepted samples in the current frame.
REQ-016 Compare value: c = x when ABS_MODE=0; c = |x| when ABS_MODE=1, saturated so that the most negative input maps to 2^(WIDTH-1)-1.
REQ-017 IDLE with v=1: the block SHALL load run_peak=c, run_idx=0, cnt=1 and go to ACC; the first sample always seeds the peak, never a compare against 0.
REQ-018 ACC with v=1: if c > run_peak (strict), the block SHALL load run_peak=c and run_idx=cnt; otherwise it SHALL hold both; cnt SHALL increment.
REQ-019 Ties: the earliest occurrence SHALL win (strict greater-than only).
REQ-020 Frame completion: when v=1 and cnt=FRAME_LEN-1, the block SHALL write the final peak (including the current sample) to peak/peak_idx, pulse vout on the next cycle, and return to IDLE with cnt=0.
REQ-021 Latency: vout=1 in the cycle after the edge that accepted the last sample of the frame; the result is visible on the same edge.
REQ-022 peak and peak_idx SHALL hold their values until the next frame completes; they SHALL NOT change mid-frame.
REQ-023 vout SHALL be high for exactly one cycle per completed frame, including back-to-back frames with v held high continuously.
REQ-024 v=0 SHALL hold all state; gaps in v of any length SHALL NOT affect the result.
REQ-025 clr=1 SHALL force IDLE and cnt=0, SHALL leave peak/peak_idx unchanged, and SHALL NOT pulse vout.
REQ-026 clr and v both high: clr SHALL win and the sample SHALL be discarded, including on what would have been the last sample of a frame.
REQ-027 busy SHALL be 1 exactly when the state is ACC.
REQ-028 No arithmetic widening: all compares are WIDTH-bit signed, or WIDTH-bit unsigned magnitude in ABS_MODE=1.

Reset
REQ-029 While rst=0: peak=0, peak_idx=0, vout=0, busy=0, state=IDLE, cnt=0, run_peak=0, run_idx=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no vout pulse; the first valid sample after release starts a new frame at index 0.

Verification (FRAME_LEN=4, WIDTH=16 unless noted)
REQ-031 ABS_MODE=0, v=1 continuous, x = -5,-3,-9,-7 -> single vout pulse, peak=-3, peak_idx=1 (negative-only frame, seeding check).
REQ-032 ABS_MODE=0, x = 7,2,7,1 then 1,2,3,4 back-to-back -> vout at cycle 5 with peak=7, idx=0 (tie: first wins); vout at cycle 9 with peak=4, idx=3.
REQ-033 ABS_MODE=1, x = 100,-32768,-200,5 -> peak=32767, peak_idx=1 (saturation).
REQ-034 x = 1,9 with v, then clr, then 3,2,8,4 -> no vout for the aborted frame; then peak=8, idx=2; clr with v on a 4th sample -> no vout.
REQ-035 v toggles randomly with 3-cycle gaps, x = 10,40,20,30 -> peak=40, idx=1; peak/peak_idx unchanged and busy=1 throughout the gaps.
REQ-036 rst pulled low asynchronously mid-frame after 2 samples -> all outputs 0 at once; next 4 samples 6,5,4,3 -> peak=6, idx=0.
